split_bus_arbiter: RTL and testbench

//  Central arbiter for the serial bus. Shares the bus between NUM_INIT initiator ports (round-robin)
//  and the split-capable target. Parks an initiator whose transaction the target splits, releases
//  the bus to others, then grants the split target to return data and unparks the initiator.

---
 rtl/serial_bus_pkg.sv | 12 +
 rtl/rr_picker.sv | 38 +++
 rtl/split_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_split_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// rtl/serial_bus_pkg.sv - shared types and limits for the serial bus arbiter
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INIT_GNT  = 2'd1,
        SPLIT_GNT = 2'd2
    } arb_state_t;

    localparam int MAX_INIT = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select over masked requests
module rr_picker #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] eligible;
    int           cand;

    assign eligible = req & ~mask;

    // Scan starting at ptr and wrapping; the first eligible requester wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && eligible[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = W'(cand);
            end
        end
    end

endmodule

// File: rtl/split_bus_arbiter.sv
// rtl/split_bus_arbiter.sv - round-robin bus arbiter with split-transaction parking
module split_bus_arbiter #(
    parameter int NUM_INIT      = 2,
    parameter int GRANT_TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INIT-1:0]         init_req,
    input  logic [NUM_INIT-1:0]         init_done,
    output logic [NUM_INIT-1:0]         init_grant,
    input  logic                        split_ack,
    input  logic                        split_req,
    input  logic                        split_done,
    output logic                        split_grant,
    output logic                        split_pending,
    output logic [$clog2(NUM_INIT)-1:0] split_owner,
    output logic                        bus_busy,
    output logic                        timeout_evt
);
    import serial_bus_pkg::*;

    localparam int IW = $clog2(NUM_INIT);
    localparam logic [15:0] TO_LAST = 16'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);

    arb_state_t          state, state_nxt;
    logic [IW-1:0]       rr_ptr, ptr_nxt;
    logic [IW-1:0]       cur_idx, cur_nxt;
    logic [15:0]         hold_cnt, cnt_nxt;
    logic [NUM_INIT-1:0] grant_nxt;
    logic                split_grant_nxt, pend_nxt, timeout_nxt;
    logic [IW-1:0]       owner_nxt;
    logic [IW-1:0]       ptr_after;
    logic [NUM_INIT-1:0] park_mask;
    logic [NUM_INIT-1:0] pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                release_init;

    // The parked initiator may not win again until its split return completes.
    assign park_mask = split_pending ? (NUM_INIT'(1) << split_owner) : '0;
    assign ptr_after = (cur_idx == IW'(NUM_INIT - 1)) ? '0 : cur_idx + IW'(1);
    assign bus_busy  = (|init_grant) | split_grant;

    rr_picker #(.N(NUM_INIT), .W(IW)) u_pick (
        .req    (init_req),
        .mask   (park_mask),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            init_grant    <= '0;
            split_grant   <= 1'b0;
            split_pending <= 1'b0;
            split_owner   <= '0;
            timeout_evt   <= 1'b0;
            rr_ptr        <= '0;
            cur_idx       <= '0;
            hold_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            init_grant    <= grant_nxt;
            split_grant   <= split_grant_nxt;
            split_pending <= pend_nxt;
            split_owner   <= owner_nxt;
            timeout_evt   <= timeout_nxt;
            rr_ptr        <= ptr_nxt;
            cur_idx       <= cur_nxt;
            hold_cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = init_grant;
        split_grant_nxt = split_grant;
        pend_nxt        = split_pending;
        owner_nxt       = split_owner;
        timeout_nxt     = 1'b0;
        ptr_nxt         = rr_ptr;
        cur_nxt         = cur_idx;
        cnt_nxt         = hold_cnt;
        release_init    = 1'b0;
        case (state)
            IDLE: begin
                if (split_req && split_pending) begin
                    state_nxt       = SPLIT_GNT;
                    split_grant_nxt = 1'b1;
                end else if (pick_any) begin
                    state_nxt = INIT_GNT;
                    grant_nxt = pick_onehot;
                    cur_nxt   = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            INIT_GNT: begin
                // Only one split may be outstanding; a second split_ack is dropped.
                if (split_ack && !split_pending) begin
                    pend_nxt     = 1'b1;
                    owner_nxt    = cur_idx;
                    release_init = 1'b1;
                end else if (init_done[cur_idx]) begin
                    release_init = 1'b1;
                end else if ((GRANT_TIMEOUT > 0) && (hold_cnt == TO_LAST)) begin
                    timeout_nxt  = 1'b1;
                    release_init = 1'b1;
                end else begin
                    cnt_nxt = hold_cnt + 16'd1;
                end
                if (release_init) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = ptr_after;
                end
            end
            SPLIT_GNT: begin
                if (split_done) begin
                    state_nxt       = IDLE;
                    split_grant_nxt = 1'b0;
                    pend_nxt        = 1'b0;
                end
            end
            default: begin
                state_nxt       = IDLE;
                grant_nxt       = '0;
                split_grant_nxt = 1'b0;
            end
        endcase
    end

    a_single_grant: assert property (@(posedge clk) disable iff (rst)
        $onehot0({init_grant, split_grant}));

endmodule

// File: tb/tb_split_bus_arbiter.sv
// tb/tb_split_bus_arbiter.sv - scoreboard bench for split_bus_arbiter
module tb_split_bus_arbiter;

    typedef struct packed {
        logic [1:0] ig;
        logic       sg;
        logic       to;
        logic       pend;
        logic       own;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] init_req = '0;
    logic [1:0] init_done = '0;
    logic [1:0] init_grant;
    logic       split_ack = 1'b0;
    logic       split_req = 1'b0;
    logic       split_done = 1'b0;
    logic       split_grant;
    logic       split_pending;
    logic       split_owner;
    logic       bus_busy;
    logic       timeout_evt;

    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];

    logic       prev_busy = 1'b0;
    logic [1:0] prev_ig = '0;
    logic       prev_sg = 1'b0;

    split_bus_arbiter #(.NUM_INIT(2), .GRANT_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_req      (init_req),
        .init_done     (init_done),
        .init_grant    (init_grant),
        .split_ack     (split_ack),
        .split_req     (split_req),
        .split_done    (split_done),
        .split_grant   (split_grant),
        .split_pending (split_pending),
        .split_owner   (split_owner),
        .bus_busy      (bus_busy),
        .timeout_evt   (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_ev(input logic [1:0] ig, input logic sg, input logic to,
                                      input logic pend, input logic own);
        ev_t e;
        e = '{ig: ig, sg: sg, to: to, pend: pend, own: own};
        exp_q.push_back(e);
    endfunction

    // Monitor: every new grant or watchdog pulse is an observable event.
    always @(negedge clk) begin : monitor
        ev_t got;
        ev_t want;
        if (rst) begin
            prev_busy <= 1'b0;
            prev_ig   <= '0;
            prev_sg   <= 1'b0;
        end else begin
            if ((init_grant != 2'b00 && prev_ig == 2'b00) || (split_grant && !prev_sg) || timeout_evt) begin
                got = '{ig: init_grant, sg: split_grant, to: timeout_evt,
                        pend: split_pending, own: split_owner};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got %0h expected none at %0t", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    chk("event", 32'(got), 32'(want));
                end
                if (!timeout_evt) begin
                    chk("turnaround", 32'(prev_busy), 32'd0);
                end
            end
            prev_busy <= bus_busy;
            prev_ig   <= init_grant;
            prev_sg   <= split_grant;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        init_req = '0;
        split_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!bus_busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus_busy) begin
            tests++;
            fails++;
            $display("FAIL wait_grant: got no grant expected grant within 30 cycles at %0t", $time);
        end
    endtask

    task automatic pulse(input logic [1:0] d, input logic ack, input logic sd);
        init_done  = d;
        split_ack  = ack;
        split_done = sd;
        @(negedge clk);
        init_done  = '0;
        split_ack  = 1'b0;
        split_done = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        // 1: reset values, async reset mid-grant, grant after release
        repeat (2) @(negedge clk);
        chk("rst_grants", 32'({split_grant, init_grant, bus_busy}), 32'd0);
        chk("rst_pending", 32'(split_pending), 32'd0);
        chk("rst_owner", 32'(split_owner), 32'd0);
        chk("rst_timeout", 32'(timeout_evt), 32'd0);
        rst = 1'b0;
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        init_req = 2'b01;
        wait_grant();
        #2 rst = 1'b1;
        #1 chk("async_rst_grants", 32'({split_grant, init_grant, bus_busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_grant();
        init_req = 2'b00;
        pulse(2'b01, 1'b0, 1'b0);

        // 2: round robin with both requesting
        do_reset();
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_ev(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        init_req = 2'b11;
        wait_grant();
        pulse(2'b01, 1'b0, 1'b0);
        wait_grant();
        pulse(2'b10, 1'b0, 1'b0);
        wait_grant();
        init_req = 2'b00;
        pulse(2'b01, 1'b0, 1'b0);

        // 3: split parks init0, init1 served, split return, init0 regranted
        do_reset();
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        init_req = 2'b01;
        wait_grant();
        init_req = 2'b11;
        pulse(2'b00, 1'b1, 1'b0);
        chk("split_grant_drop", 32'(init_grant), 32'd0);
        chk("split_pending_set", 32'(split_pending), 32'd1);
        chk("split_owner0", 32'(split_owner), 32'd0);
        expect_ev(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_grant();
        pulse(2'b00, 1'b1, 1'b0);
        chk("second_ack_ignored", 32'(init_grant), 32'h2);
        chk("owner_kept", 32'(split_owner), 32'd0);
        expect_ev(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        split_req = 1'b1;
        init_req = 2'b01;
        pulse(2'b10, 1'b0, 1'b0);
        wait_grant();
        split_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("split_hold_no_req", 32'(split_grant), 32'd1);
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(2'b00, 1'b0, 1'b1);
        chk("split_pending_clear", 32'({split_pending, split_grant}), 32'd0);
        wait_grant();
        init_req = 2'b00;
        pulse(2'b01, 1'b0, 1'b0);

        // 4: parked init1; split return beats a waiting initiator
        do_reset();
        expect_ev(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        init_req = 2'b10;
        wait_grant();
        init_req = 2'b01;
        split_req = 1'b1;
        expect_ev(2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        pulse(2'b00, 1'b1, 1'b0);
        chk("split_owner1", 32'(split_owner), 32'd1);
        wait_grant();
        split_req = 1'b0;
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse(2'b00, 1'b0, 1'b1);
        wait_grant();
        init_req = 2'b00;
        pulse(2'b01, 1'b0, 1'b0);

        // 5: split_ack and done in the same cycle park the transaction
        do_reset();
        expect_ev(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        init_req = 2'b01;
        wait_grant();
        init_req = 2'b00;
        pulse(2'b01, 1'b1, 1'b0);
        chk("collide_pending", 32'(split_pending), 32'd1);
        chk("collide_owner", 32'(split_owner), 32'd0);
        expect_ev(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        split_req = 1'b1;
        wait_grant();
        split_req = 1'b0;
        pulse(2'b00, 1'b0, 1'b1);
        chk("collide_cleared", 32'(split_pending), 32'd0);

        // 6: watchdog revokes init1 after four grant cycles
        do_reset();
        expect_ev(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_ev(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        init_req = 2'b10;
        wait_grant();
        init_req = 2'b00;
        n = 0;
        while (bus_busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("wd_cycles", 32'(n), 32'd4);
        chk("wd_evt", 32'(timeout_evt), 32'd1);
        @(negedge clk);
        chk("wd_evt_pulse", 32'(timeout_evt), 32'd0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish by 200000");
        $fatal(1, "time limit");
    end

endmodule
